can_tx_frame_loader: RTL and testbench

CAN_TX_FRAME_LOADER -- requirements
Module: can_tx_frame_loader

---
 rtl/can_tx_frame_loader_if.sv | 42 ++++
 rtl/can_tx_frame_loader.sv | 148 ++++++++++++++
 tb/tb_can_tx_frame_loader.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/can_tx_frame_loader_if.sv
// Bundle between the Tx frame loader, the Tx FIFO and the CAN bit transmitter.
//   master : the loader (pops the FIFO, presents a frame, reports status)
//   slave  : the environment (FIFO + transmitter side)
// Signals:
//   i_fifo_empty, i_fifo_r_data, o_fifo_r_en        : Tx FIFO read port
//   o_tx_req, i_tx_ack                               : frame hand-off
//   i_tx_done, i_tx_arb_lost, i_tx_error             : transmitter status pulses
//   o_tx_id, o_tx_ide, o_tx_rtr, o_tx_dlc, o_tx_data : frame fields
//   o_busy, o_sent, o_dropped, o_error               : loader status
interface can_tx_frame_loader_if #(
  parameter int DATA_WIDTH = 128
);
  logic                  i_fifo_empty;
  logic [DATA_WIDTH-1:0] i_fifo_r_data;
  logic                  o_fifo_r_en;
  logic                  o_tx_req;
  logic                  i_tx_ack;
  logic                  i_tx_done;
  logic                  i_tx_arb_lost;
  logic                  i_tx_error;
  logic [28:0]           o_tx_id;
  logic                  o_tx_ide;
  logic                  o_tx_rtr;
  logic [3:0]            o_tx_dlc;
  logic [63:0]           o_tx_data;
  logic                  o_busy;
  logic                  o_sent;
  logic                  o_dropped;
  logic                  o_error;

  modport master (
    input  i_fifo_empty, i_fifo_r_data, i_tx_ack, i_tx_done, i_tx_arb_lost, i_tx_error,
    output o_fifo_r_en, o_tx_req, o_tx_id, o_tx_ide, o_tx_rtr, o_tx_dlc, o_tx_data,
           o_busy, o_sent, o_dropped, o_error
  );

  modport slave (
    output i_fifo_empty, i_fifo_r_data, i_tx_ack, i_tx_done, i_tx_arb_lost, i_tx_error,
    input  o_fifo_r_en, o_tx_req, o_tx_id, o_tx_ide, o_tx_rtr, o_tx_dlc, o_tx_data,
           o_busy, o_sent, o_dropped, o_error
  );
endinterface

// File: rtl/can_tx_frame_loader.sv
// CAN Tx frame loader: pops one word from the Tx FIFO, decodes it into frame
// fields, requests the bit transmitter and re-requests after arbitration loss
// or bus error until the retry budget is spent.
// Ports:
//   i_sys_clk : clock, rising edge
//   i_reset   : synchronous, active-high reset
//   bus       : can_tx_frame_loader_if.master (FIFO, transmitter, frame, status)
// Parameters:
//   MAX_RETRY  : re-requests allowed after a failed attempt before dropping
//   DATA_WIDTH : FIFO word width (fields are decoded from bits [127:0])

// One payload byte: kept only for data frames whose dlc covers this index.
// dlc values 9..15 exceed every index, so they keep all eight bytes.
module can_tx_byte_lane #(
  parameter int IDX = 0
) (
  input  logic [7:0] din,
  input  logic [3:0] dlc,
  input  logic       rtr,
  output logic [7:0] dout
);
  localparam logic [3:0] IDX_L = 4'(IDX);
  assign dout = (!rtr && (dlc > IDX_L)) ? din : 8'h00;
endmodule

module can_tx_frame_loader #(
  parameter int MAX_RETRY  = 8,
  parameter int DATA_WIDTH = 128
) (
  input  logic                   i_sys_clk,
  input  logic                   i_reset,
  can_tx_frame_loader_if.master  bus
);
  localparam int              CNT_W   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_RETRY);

  typedef enum logic [2:0] {IDLE, POP, LOAD, REQ, WAIT, RETRY} state_t;

  typedef struct packed {
    logic [28:0] id;
    logic        ide;
    logic        rtr;
    logic [3:0]  dlc;
    logic [63:0] data;
  } frame_t;

  state_t            state, nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              sent_nxt, drop_nxt, err_nxt;
  logic              sent_q, drop_q, err_q;
  frame_t            dec, frm;
  logic [DATA_WIDTH-1:0] word;
  logic [63:0]       data_masked;

  assign word = bus.i_fifo_r_data;

  // Bits [92:64] carry nothing for the transmitter.
  logic unused_bits;
  assign unused_bits = ^word[92:64];

  // Byte 0 sits in the most significant byte of the payload.
  for (genvar b = 0; b < 8; b++) begin : g_lane
    can_tx_byte_lane #(.IDX(b)) u_lane (
      .din  (word[63-8*b -: 8]),
      .dlc  (word[96:93]),
      .rtr  (word[97]),
      .dout (data_masked[63-8*b -: 8])
    );
  end

  always_comb begin
    dec.ide  = word[98];
    dec.rtr  = word[97];
    dec.dlc  = word[96:93];
    dec.data = data_masked;
    // Standard frames carry an 11-bit identifier only.
    dec.id   = word[98] ? word[127:99] : {18'd0, word[109:99]};
  end

  always_ff @(posedge i_sys_clk) begin
    if (i_reset) begin
      state  <= IDLE;
      cnt    <= '0;
      frm    <= '0;
      sent_q <= 1'b0;
      drop_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state  <= nxt;
      cnt    <= cnt_nxt;
      sent_q <= sent_nxt;
      drop_q <= drop_nxt;
      err_q  <= err_nxt;
      // FIFO data is valid in LOAD (one cycle after the pop strobe).
      if (state == LOAD) frm <= dec;
    end
  end

  always_comb begin
    nxt      = state;
    cnt_nxt  = cnt;
    sent_nxt = 1'b0;
    drop_nxt = 1'b0;
    err_nxt  = 1'b0;
    unique case (state)
      IDLE:  if (!bus.i_fifo_empty) nxt = POP;
      POP:   nxt = LOAD;
      LOAD:  nxt = REQ;
      REQ:   if (bus.i_tx_ack) nxt = WAIT;
      WAIT: begin
        // done wins over error, error over arbitration loss
        if (bus.i_tx_done) begin
          sent_nxt = 1'b1;
          cnt_nxt  = '0;
          nxt      = IDLE;
        end else if (bus.i_tx_error) begin
          err_nxt  = 1'b1;
          nxt      = RETRY;
        end else if (bus.i_tx_arb_lost) begin
          nxt      = RETRY;
        end
      end
      RETRY: begin
        if (cnt < MAX_CNT) begin
          cnt_nxt  = cnt + CNT_W'(1);
          nxt      = REQ;
        end else begin
          drop_nxt = 1'b1;
          cnt_nxt  = '0;
          nxt      = IDLE;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  assign bus.o_fifo_r_en = (state == POP);
  assign bus.o_tx_req    = (state == REQ);
  assign bus.o_busy      = (state != IDLE);
  assign bus.o_sent      = sent_q;
  assign bus.o_dropped   = drop_q;
  assign bus.o_error     = err_q;
  assign bus.o_tx_id     = frm.id;
  assign bus.o_tx_ide    = frm.ide;
  assign bus.o_tx_rtr    = frm.rtr;
  assign bus.o_tx_dlc    = frm.dlc;
  assign bus.o_tx_data   = frm.data;
endmodule

// File: tb/tb_can_tx_frame_loader.sv
module tb_can_tx_frame_loader;
  localparam int MAX_R = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  can_tx_frame_loader_if #(.DATA_WIDTH(128)) bus();

  can_tx_frame_loader #(.MAX_RETRY(MAX_R), .DATA_WIDTH(128)) dut (
    .i_sys_clk (clk),
    .i_reset   (rst),
    .bus       (bus)
  );

  int n_cmp = 0, n_bad = 0;
  int n_sent = 0, n_drop = 0, n_err = 0, n_pop = 0;
  bit chk_en = 1'b0;
  logic [127:0] cur_word = '0;

  // outcome codes for one attempt
  localparam int ARB = 0, ERR = 1, DONE = 2, DONE_ARB = 3, ERR_ARB = 4, DONE_ERR = 5;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: frame fields the transmitter must see for a FIFO word.
  function automatic logic [98:0] exp_frame(input logic [127:0] w);
    logic [28:0] id;
    logic [63:0] data, mask;
    int n;
    id = w[127:99];
    if (!w[98]) id = id & 29'h7FF;
    n = int'(w[96:93]);
    if (n > 8) n = 8;
    mask = (n == 0) ? 64'd0 : (~64'd0 << (64 - 8 * n));
    data = w[97] ? 64'd0 : (w[63:0] & mask);
    return {id, w[98], w[97], w[96:93], data};
  endfunction

  function automatic logic [127:0] mk(input logic [28:0] id, input logic ide, input logic rtr,
                                      input logic [3:0] dlc, input logic [63:0] d);
    logic [28:0] junk;
    junk = 29'($urandom);
    return {id, ide, rtr, dlc, junk, d};
  endfunction

  function automatic logic [98:0] dut_frame();
    return {bus.o_tx_id, bus.o_tx_ide, bus.o_tx_rtr, bus.o_tx_dlc, bus.o_tx_data};
  endfunction

  // Single compare process: frame must match the model on every request cycle;
  // also tallies status pulses and pops for per-frame totals.
  always @(negedge clk) begin
    if (bus.o_sent === 1'b1)      n_sent++;
    if (bus.o_dropped === 1'b1)   n_drop++;
    if (bus.o_error === 1'b1)     n_err++;
    if (bus.o_fifo_r_en === 1'b1) n_pop++;
    if (chk_en && bus.o_tx_req === 1'b1)
      chk("frame_on_req", 128'(dut_frame()), 128'(exp_frame(cur_word)));
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle_gap(input int k);
    for (int j = 0; j < k; j++) begin
      bus.i_tx_done     = 1'($urandom);
      bus.i_tx_arb_lost = 1'($urandom);
      bus.i_tx_error    = 1'($urandom);
      step();
      bus.i_tx_done = 0; bus.i_tx_arb_lost = 0; bus.i_tx_error = 0;
      chk("idle_busy", 128'(bus.o_busy), 128'(0));
      chk("idle_no_pop", 128'(bus.o_fifo_r_en), 128'(0));
    end
  endtask

  task automatic run_frame(input logic [127:0] w, input int oc[0:7], input bit use_lit,
                           input logic [98:0] lit);
    int s0, d0, e0, p0, att, fails, x_err;
    bit x_sent, is_done, is_err;
    // model of the attempt sequence
    att = 0; fails = 0; x_err = 0; x_sent = 0;
    for (int i = 0; i < 8; i++) begin
      att++;
      if (oc[i] == DONE || oc[i] == DONE_ARB || oc[i] == DONE_ERR) begin x_sent = 1; break; end
      if (oc[i] == ERR || oc[i] == ERR_ARB) x_err++;
      fails++;
      if (fails > MAX_R) break;
    end
    s0 = n_sent; d0 = n_drop; e0 = n_err; p0 = n_pop;
    cur_word = w;
    bus.i_fifo_r_data = {$urandom, $urandom, $urandom, $urandom};
    bus.i_fifo_empty = 0;
    step();
    chk("r_en_latency", 128'(bus.o_fifo_r_en), 128'(1));
    bus.i_fifo_empty = 1;
    step();
    chk("r_en_single", 128'(bus.o_fifo_r_en), 128'(0));
    bus.i_fifo_r_data = w;
    step();
    bus.i_fifo_r_data = {$urandom, $urandom, $urandom, $urandom};
    chk("req_latency", 128'(bus.o_tx_req), 128'(1));
    if (use_lit) chk("literal_frame", 128'(dut_frame()), 128'(lit));
    for (int a = 0; a < att; a++) begin
      // stall in REQ; status pulses here must be ignored
      for (int j = 0, k = $urandom_range(0, 3); j < k; j++) begin
        bus.i_tx_done = 1'($urandom); bus.i_tx_arb_lost = 1'($urandom);
        bus.i_tx_error = 1'($urandom);
        step();
        bus.i_tx_done = 0; bus.i_tx_arb_lost = 0; bus.i_tx_error = 0;
        chk("req_hold", 128'(bus.o_tx_req), 128'(1));
      end
      bus.i_tx_ack = 1;
      step();
      bus.i_tx_ack = 0;
      chk("req_drop_after_ack", 128'(bus.o_tx_req), 128'(0));
      chk("busy_in_wait", 128'(bus.o_busy), 128'(1));
      for (int j = 0, k = $urandom_range(0, 2); j < k; j++) step();
      is_done = (oc[a] == DONE || oc[a] == DONE_ARB || oc[a] == DONE_ERR);
      is_err  = (oc[a] == ERR || oc[a] == ERR_ARB || oc[a] == DONE_ERR);
      bus.i_tx_done     = is_done;
      bus.i_tx_error    = is_err;
      bus.i_tx_arb_lost = (oc[a] == ARB || oc[a] == DONE_ARB || oc[a] == ERR_ARB);
      step();
      bus.i_tx_done = 0; bus.i_tx_arb_lost = 0; bus.i_tx_error = 0;
      if (is_done) begin
        chk("sent_pulse", 128'(bus.o_sent), 128'(1));
        chk("idle_after_sent", 128'(bus.o_busy), 128'(0));
      end else begin
        step();
        if (a == att - 1) begin
          chk("dropped_pulse", 128'(bus.o_dropped), 128'(1));
          chk("idle_after_drop", 128'(bus.o_busy), 128'(0));
        end else begin
          chk("re_request", 128'(bus.o_tx_req), 128'(1));
        end
      end
    end
    step(); step();
    chk("sent_count", 128'(n_sent - s0), 128'(x_sent ? 1 : 0));
    chk("drop_count", 128'(n_drop - d0), 128'(x_sent ? 0 : 1));
    chk("error_count", 128'(n_err - e0), 128'(x_err));
    chk("pop_count", 128'(n_pop - p0), 128'(1));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    int oc[0:7];
    logic [127:0] w;
    int p0;
    bus.i_fifo_empty = 1; bus.i_fifo_r_data = '0; bus.i_tx_ack = 0;
    bus.i_tx_done = 0; bus.i_tx_arb_lost = 0; bus.i_tx_error = 0;
    step(); step(); step();
    rst = 0;
    chk("reset_frame", 128'(dut_frame()), 128'(0));
    chk("reset_status", 128'({bus.o_busy, bus.o_tx_req, bus.o_fifo_r_en, bus.o_sent,
                             bus.o_dropped, bus.o_error}), 128'(0));
    chk_en = 1;
    step();

    // basic data frame, dlc 2
    oc = '{DONE, 0, 0, 0, 0, 0, 0, 0};
    run_frame(mk(29'h123, 0, 0, 4'd2, 64'hAABBCCDD_00000000), oc, 1,
              {29'h123, 1'b0, 1'b0, 4'd2, 64'hAABB0000_00000000});
    // retries up to the budget, then success
    oc = '{ARB, ARB, DONE, 0, 0, 0, 0, 0};
    run_frame(mk(29'h0ABC, 0, 0, 4'd8, 64'h0123456789ABCDEF), oc, 1,
              {29'h2BC, 1'b0, 1'b0, 4'd8, 64'h0123456789ABCDEF});
    // budget exhausted: three requests then drop; next word still popped
    oc = '{ARB, ARB, ARB, 0, 0, 0, 0, 0};
    run_frame(mk(29'h7FF, 0, 0, 4'd1, 64'h1122334455667788), oc, 1,
              {29'h7FF, 1'b0, 1'b0, 4'd1, 64'h1100000000000000});
    // done with arb loss in the same cycle
    oc = '{DONE_ARB, 0, 0, 0, 0, 0, 0, 0};
    run_frame(mk(29'h001, 0, 0, 4'd0, 64'hFFFFFFFFFFFFFFFF), oc, 1,
              {29'h001, 1'b0, 1'b0, 4'd0, 64'h0});
    // remote frame, dlc 15
    oc = '{ERR, DONE_ERR, 0, 0, 0, 0, 0, 0};
    run_frame(mk(29'h155, 0, 1, 4'd15, 64'hFFFFFFFFFFFFFFFF), oc, 1,
              {29'h155, 1'b0, 1'b1, 4'd15, 64'h0});
    // extended id passes through; dlc 9 masks as 8
    oc = '{ERR_ARB, ERR, DONE, 0, 0, 0, 0, 0};
    run_frame(mk(29'h1FFFFFFF, 1, 0, 4'd9, 64'hDEADBEEFCAFEF00D), oc, 1,
              {29'h1FFFFFFF, 1'b1, 1'b0, 4'd9, 64'hDEADBEEFCAFEF00D});
    // standard frame clears the upper id bits
    oc = '{DONE, 0, 0, 0, 0, 0, 0, 0};
    run_frame(mk(29'h1FFFFFFF, 0, 0, 4'd5, 64'h0102030405060708), oc, 1,
              {29'h7FF, 1'b0, 1'b0, 4'd5, 64'h0102030405000000});

    // reset while waiting for the transmitter, with a done pulse on the same edge
    p0 = n_pop;
    w = mk(29'h3A5, 1, 0, 4'd4, 64'h8877665544332211);
    cur_word = w;
    bus.i_fifo_empty = 0; step();
    bus.i_fifo_empty = 1; step();
    bus.i_fifo_r_data = w; step();
    bus.i_tx_ack = 1; step();
    bus.i_tx_ack = 0;
    rst = 1; bus.i_tx_done = 1; step();
    rst = 0; bus.i_tx_done = 0;
    chk("rst_wait_frame", 128'(dut_frame()), 128'(0));
    chk("rst_wait_status", 128'({bus.o_busy, bus.o_tx_req, bus.o_fifo_r_en, bus.o_sent,
                               bus.o_dropped, bus.o_error}), 128'(0));
    idle_gap(4);
    chk("rst_no_repop", 128'(n_pop - p0), 128'(1));

    // randomized frames and outcomes
    for (int f = 0; f < 150; f++) begin
      logic [3:0] dlc;
      dlc = 4'($urandom);
      w = mk(29'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0), dlc,
             {$urandom, $urandom});
      for (int i = 0; i < 8; i++) oc[i] = $urandom_range(0, 5);
      run_frame(w, oc, 0, '0);
      idle_gap($urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
